gaussian_blur: RTL

GAUSSIAN_BLUR -- requirements
Module: gaussian_blur

---
 rtl/gaussian_blur_pkg.sv | 16 +
 rtl/gaussian_blur_kernel.sv | 34 +++
 rtl/gaussian_blur.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gaussian_blur_pkg.sv
// Shared constants for the blur pipeline: FSM encoding, 3x3 kernel weights
// and the normalisation shift.
package gaussian_blur_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } blur_state_t;

    // Row-major 1-2-1 / 2-4-2 / 1-2-1 kernel; weights sum to 1 << NORM_SHIFT.
    localparam int unsigned KERNEL_TAPS = 9;
    localparam int unsigned KERNEL_WEIGHTS [KERNEL_TAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    localparam int unsigned NORM_SHIFT = 4;

endpackage

// File: rtl/gaussian_blur_kernel.sv
// Combinational 3x3 Gaussian weighted sum, normalised by truncating shift.
module gaussian_kernel
    import gaussian_blur_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic [DWIDTH-1:0] p00,
    input  logic [DWIDTH-1:0] p01,
    input  logic [DWIDTH-1:0] p02,
    input  logic [DWIDTH-1:0] p10,
    input  logic [DWIDTH-1:0] p11,
    input  logic [DWIDTH-1:0] p12,
    input  logic [DWIDTH-1:0] p20,
    input  logic [DWIDTH-1:0] p21,
    input  logic [DWIDTH-1:0] p22,
    output logic [DWIDTH-1:0] dout
);

    localparam int ACC_W = DWIDTH + NORM_SHIFT;

    logic [DWIDTH-1:0] pix [KERNEL_TAPS];
    logic [ACC_W-1:0]  acc;

    assign pix = '{p00, p01, p02, p10, p11, p12, p20, p21, p22};

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
            acc = acc + ACC_W'(pix[i]) * ACC_W'(KERNEL_WEIGHTS[i]);
        end
        dout = acc[ACC_W-1:NORM_SHIFT];
    end

endmodule

// File: rtl/gaussian_blur.sv
// Streaming 3x3 Gaussian blur between two FWFT FIFOs using a two-row line
// shift register; border pixels of each frame are forced to zero.
module gaussian_blur
    import gaussian_blur_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH     = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              fifo_in_rd_en,
    input  logic [DWIDTH-1:0] fifo_in_dout,
    input  logic              fifo_in_empty,
    output logic              fifo_out_wr_en,
    output logic [DWIDTH-1:0] fifo_out_din,
    input  logic              fifo_out_full
);

    localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int SR_LEN = 2 * IMG_WIDTH + 2;
    localparam int CNT_W  = $clog2(PIXELS + 1);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);
    localparam int COL_W  = $clog2(IMG_WIDTH);

    blur_state_t       state, next_state;
    logic              advance;
    logic              last_out;
    logic              border;
    logic [DWIDTH-1:0] pix_in;
    logic [DWIDTH-1:0] blur;
    logic [CNT_W-1:0]  in_cnt;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic [DWIDTH-1:0] sr [SR_LEN];

    assign last_out = (out_row == ROW_W'(IMG_HEIGHT - 1)) && (out_col == COL_W'(IMG_WIDTH - 1));
    assign border   = (out_row == '0) || (out_row == ROW_W'(IMG_HEIGHT - 1)) ||
                      (out_col == '0) || (out_col == COL_W'(IMG_WIDTH - 1));

    always_comb begin
        next_state     = state;
        advance        = 1'b0;
        fifo_in_rd_en  = 1'b0;
        fifo_out_wr_en = 1'b0;
        pix_in         = fifo_in_dout;
        case (state)
            FILL: begin
                advance       = !fifo_in_empty;
                fifo_in_rd_en = advance;
                if (advance && in_cnt == CNT_W'(IMG_WIDTH))
                    next_state = RUN;
            end
            RUN: begin
                advance        = !fifo_in_empty && !fifo_out_full;
                fifo_in_rd_en  = advance;
                fifo_out_wr_en = advance;
                if (advance && in_cnt == CNT_W'(PIXELS - 1))
                    next_state = FLUSH;
            end
            FLUSH: begin
                advance        = !fifo_out_full;
                fifo_out_wr_en = advance;
                pix_in         = '0;
                if (advance && last_out)
                    next_state = FILL;
            end
            default: next_state = FILL;
        endcase
        // Enables must stay quiet while reset is held, even though FILL reads.
        if (reset) begin
            advance        = 1'b0;
            fifo_in_rd_en  = 1'b0;
            fifo_out_wr_en = 1'b0;
        end
    end

    gaussian_kernel #(
        .DWIDTH(DWIDTH)
    ) u_kernel (
        .p00 (sr[2*IMG_WIDTH+1]),
        .p01 (sr[2*IMG_WIDTH]),
        .p02 (sr[2*IMG_WIDTH-1]),
        .p10 (sr[IMG_WIDTH+1]),
        .p11 (sr[IMG_WIDTH]),
        .p12 (sr[IMG_WIDTH-1]),
        .p20 (sr[1]),
        .p21 (sr[0]),
        .p22 (pix_in),
        .dout(blur)
    );

    assign fifo_out_din = (reset || border) ? '0 : blur;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= FILL;
            in_cnt  <= '0;
            out_row <= '0;
            out_col <= '0;
            for (int unsigned i = 0; i < SR_LEN; i++)
                sr[i] <= '0;
        end else begin
            state <= next_state;
            if (advance) begin
                sr[0] <= pix_in;
                for (int unsigned i = 1; i < SR_LEN; i++)
                    sr[i] <= sr[i-1];
                if (state == FLUSH && last_out) begin
                    in_cnt  <= '0;
                    out_row <= '0;
                    out_col <= '0;
                end else begin
                    if (state != FLUSH)
                        in_cnt <= in_cnt + CNT_W'(1);
                    if (state != FILL) begin
                        if (out_col == COL_W'(IMG_WIDTH - 1)) begin
                            out_col <= '0;
                            out_row <= out_row + ROW_W'(1);
                        end else begin
                            out_col <= out_col + COL_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule
